// File: rtl/sass_pkg.sv
// Shared constants, FSM encoding and helpers for the SASS triple-redundant
// receiver controller and its voter.
package sass_pkg;
  localparam int DATA_L = 14;
  localparam int FCNT_W = 4;
  localparam int N_CH   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  function automatic logic [1:0] ones3(input logic [2:0] m);
    return 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
  endfunction
endpackage

// File: rtl/sass_vote3.sv
// Combinational three-way bitwise majority voter with per-input mismatch flags.
module sass_vote3
  import sass_pkg::*;
#(
  parameter int data_l = DATA_L
) (
  input  logic [data_l-1:0] i_a,
  input  logic [data_l-1:0] i_b,
  input  logic [data_l-1:0] i_c,
  output logic [data_l-1:0] o_maj,
  output logic [2:0]        o_mism
);
  assign o_maj  = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_mism = {|(i_c ^ o_maj), |(i_b ^ o_maj), |(i_a ^ o_maj)};
endmodule

// File: rtl/sass_tmr_ctrl.sv
// Collects words from three SASS receivers inside a time window, votes them,
// hands the result out over a valid/ready port and tracks per-channel faults.
module sass_tmr_ctrl
  import sass_pkg::*;
#(
  parameter int data_l   = DATA_L,
  parameter int win      = 8,
  parameter int fault_th = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        avl_in,
  input  logic [data_l-1:0] data0,
  input  logic [data_l-1:0] data1,
  input  logic [data_l-1:0] data2,
  input  logic              mode,
  input  logic              fault_clr,
  output logic              out_valid,
  output logic [data_l-1:0] out_data,
  input  logic              out_ready,
  output logic              err,
  output logic              ovr,
  output logic [2:0]        fault
);
  localparam int CNT_W = $clog2(win) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(win - 1);
  localparam logic [FCNT_W-1:0] FCNT_TH  = FCNT_W'(fault_th);
  localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

  state_t                        r_state, w_state_next;
  logic [2:0]                    r_en, w_en_next;
  logic [2:0]                    r_cap, w_cap_next;
  logic                          r_mode, w_mode_next;
  logic [CNT_W-1:0]              r_cnt, w_cnt_next;
  logic                          r_out_valid, w_out_valid_next;
  logic [data_l-1:0]             r_out_data, w_out_data_next;
  logic                          r_err, w_err_next;
  logic                          r_ovr, w_ovr_next;
  logic [2:0]                    w_load, w_inc;

  logic [N_CH-1:0][data_l-1:0]   w_din, w_dq;
  logic [2:0]                    w_fault, w_en_live;
  logic [2:0]                    w_new_idle, w_new_col, w_dup, w_hit, w_miss, w_cap_all;
  logic [data_l-1:0]             w_maj;
  logic [2:0]                    w_mism;

  assign w_din = {data2, data1, data0};

  // Per-channel capture register and saturating fault counter.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [data_l-1:0] r_word;
      logic [FCNT_W-1:0] r_fcnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_word <= '0;
        end else if (w_load[gi]) begin
          r_word <= w_din[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || fault_clr) begin
          r_fcnt <= '0;
        end else if (w_inc[gi] && (r_fcnt != FCNT_MAX)) begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end

      assign w_dq[gi]    = r_word;
      assign w_fault[gi] = (r_fcnt >= FCNT_TH);
    end
  endgenerate

  sass_vote3 #(.data_l(data_l)) u_vote (
    .i_a    (w_dq[0]),
    .i_b    (w_dq[1]),
    .i_c    (w_dq[2]),
    .o_maj  (w_maj),
    .o_mism (w_mism)
  );

  // The live enabled set only matters in IDLE; afterwards r_en is authoritative.
  assign w_en_live  = mode ? ~w_fault : 3'b001;
  assign w_new_idle = avl_in & w_en_live;
  assign w_new_col  = avl_in & r_en & ~r_cap;
  assign w_dup      = avl_in & r_en & r_cap;
  assign w_hit      = avl_in & r_en;
  assign w_miss     = r_en & ~r_cap;
  assign w_cap_all  = r_cap | w_new_col;

  always_comb begin
    w_state_next     = r_state;
    w_en_next        = r_en;
    w_mode_next      = r_mode;
    w_cap_next       = r_cap;
    w_cnt_next       = r_cnt;
    w_load           = '0;
    w_inc            = '0;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    w_err_next       = 1'b0;
    w_ovr_next       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (|w_new_idle) begin
          w_load      = w_new_idle;
          w_cap_next  = w_new_idle;
          w_en_next   = w_en_live;
          w_mode_next = mode;
          w_cnt_next  = '0;
          w_state_next = (w_new_idle == w_en_live) ? ST_VOTE : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        w_load     = w_new_col;
        w_cap_next = w_cap_all;
        w_cnt_next = r_cnt + 1'b1;
        w_ovr_next = |w_dup;
        if ((w_cap_all == r_en) || (w_cnt_next == CNT_LAST)) begin
          w_state_next = ST_VOTE;
        end
      end

      ST_VOTE: begin
        w_ovr_next   = |w_hit;
        w_cap_next   = '0;
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
        if (!r_mode) begin
          w_out_data_next  = w_dq[0];
          w_out_valid_next = 1'b1;
          w_state_next     = ST_OUT;
        end else if (ones3(r_cap) == 2'd3) begin
          w_out_data_next  = w_maj;
          w_out_valid_next = 1'b1;
          w_inc            = w_mism;
          w_state_next     = ST_OUT;
        end else if (ones3(r_cap) == 2'd2) begin
          // With two captured words the majority equals them iff they agree.
          if ((w_mism & r_cap) == 3'b000) begin
            w_out_data_next  = w_maj;
            w_out_valid_next = 1'b1;
            w_inc            = w_miss;
            w_state_next     = ST_OUT;
          end else begin
            w_err_next = 1'b1;
          end
        end else begin
          w_err_next = 1'b1;
          w_inc      = w_miss;
        end
      end

      ST_OUT: begin
        w_ovr_next = |w_hit;
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_state_next     = ST_IDLE;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_en        <= '0;
      r_mode      <= 1'b0;
      r_cap       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_en        <= w_en_next;
      r_mode      <= w_mode_next;
      r_cap       <= w_cap_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_err       <= w_err_next;
      r_ovr       <= w_ovr_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err       = r_err;
  assign ovr       = r_ovr;
  assign fault     = w_fault;
endmodule

// File: doc/sass_tmr_ctrl.md
SASS_TMR_CTRL -- requirements
Module: sass_tmr_ctrl

Interface
REQ-001 Parameter data_l, default 14, received word width, equal to the three SASS receivers' data width.
REQ-002 Parameter win, default 8, collection window in clk cycles measured from the first accepted avl.
REQ-003 Parameter fault_th, default 3, mismatch count at which a channel is declared faulty (range 1..15).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 avl_in  in  3  one-cycle data-available pulses from receiver channels 2..0.
REQ-007 data0, data1, data2  in  data_l each  receiver words, valid in the cycle the matching avl_in bit is 1.
REQ-008 mode  in  1  0 = simplex (channel 0 only), 1 = TMR.
REQ-009 fault_clr  in  1  clears all fault counters and fault flags.
REQ-010 out_valid  out  1  voted word available; held until accepted.
REQ-011 out_data  out  data_l  voted word, stable while out_valid = 1.
REQ-012 out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
REQ-013 err  out  1  one-cycle pulse: no majority or too few channels in the window.
REQ-014 ovr  out  1  one-cycle pulse: avl dropped because the block was busy.
REQ-015 fault  out  3  per-channel faulty flag.

Function
REQ-016 Enabled set: {0} when mode = 0; otherwise channels with fault[i] = 0; the enabled set is sampled on entry to COLLECT.
REQ-017 FSM states IDLE, COLLECT, VOTE, OUT.
REQ-018 IDLE: the first cycle with avl_in & enabled nonzero captures those words, sets the captured mask, clears the window counter and moves to COLLECT; avl_in bits from disabled channels are ignored.
REQ-019 COLLECT: each further enabled avl_in captures its word once; a repeated avl on an already-captured channel pulses ovr and is dropped.
REQ-020 COLLECT exits to VOTE when the captured mask equals the enabled set, or when the window counter reaches win-1 (counter increments every COLLECT cycle).
REQ-021 Latency: if all enabled channels arrive in the same cycle T, VOTE is at T+1 and out_valid rises at T+2; the worst case is first avl at T, out_valid at T+win+1.
REQ-022 VOTE with 3 captured: out_data = bitwise majority; each channel whose word differs from the result increments its fault counter.
REQ-023 VOTE with 2 captured: if the words are equal, output that word; else pulse err, produce no output, and increment no counter.
REQ-024 VOTE in TMR with fewer than 2 captured: pulse err, produce no output, return to IDLE.
REQ-025 VOTE in simplex with channel 0 captured: output the word unvoted.
REQ-026 In TMR, any enabled channel not captured at VOTE increments its fault counter.
REQ-027 Fault counters are 4-bit and saturating; fault[i] = 1 when counter i >= fault_th.
REQ-028 OUT: hold out_valid/out_data until out_ready = 1, then return to IDLE the next cycle; out_ready = 1 in the first OUT cycle is a legal accept.
REQ-029 Any enabled avl_in while in VOTE or OUT pulses ovr and is discarded.
REQ-030 fault_clr has priority over a same-cycle counter increment; fault_clr does not alter the FSM state.
REQ-031 If the enabled set is empty (all three faulty in TMR), all avl_in are ignored and the block stays in IDLE.

Reset
REQ-032 With rst = 1 at a clock edge: state = IDLE, out_valid = 0, out_data = 0, err = 0, ovr = 0, fault = 0, fault counters = 0, captured mask = 0, window counter = 0.
REQ-033 Reset mid-operation discards any captured or pending word without emitting out_valid or err.

Structure
REQ-034 The shared package sass_pkg holds data_l, the FSM state encoding and the fault counter width.
REQ-035 Sub-module sass_vote3 is combinational: three words in, bitwise-majority word and 3-bit mismatch mask out.

Verification (data_l = 14, win = 8, fault_th = 3)
REQ-036 TMR, all avl_in = 111 at T with data 0x1234 each -> out_valid = 1 at T+2 with out_data 0x1234; fault = 000.
REQ-037 TMR, data 0x1234, 0x1234, 0x0234 same cycle, repeated 3 words, out_ready = 1 -> each out_data = 0x1234; fault = 100 after the third word; the fourth word is taken from channels 0 and 1 only.
REQ-038 TMR, only channel 0 pulses (0x0ABC) -> VOTE at T+8, err pulse, no out_valid, channels 1 and 2 counters each = 1.
REQ-039 Simplex, avl_in = 001 with 0x3FFF, out_ready held 0 for 5 cycles; avl_in = 001 again during OUT -> out_data 0x3FFF held, ovr pulse, a single accepted word.
REQ-040 rst asserted in COLLECT after one capture, then released -> no out_valid and no err; the next full triple is voted normally.
REQ-041 fault = 011 plus fault_clr and a same-cycle mismatch -> fault = 000 and counters = 0 the next cycle.
